imm_extend_stage: RTL

//  Registered immediate-extension pipeline stage between instruction decode and ALU operand select.

---
 rtl/imm_extend_if.sv | 25 ++
 rtl/imm_extend_stage.sv | 96 +++++++++
 2 files changed

// File: rtl/imm_extend_if.sv
// Handshake bundle for imm_extend_stage: upstream valid/ready + immediate/mode,
// downstream valid/ready + extended immediate/error. slave = stage side.
interface imm_extend_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  imm_i;
  logic [1:0]       mode_i;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] imm_o;
  logic             err_o;

  modport slave (
    input  in_valid, imm_i, mode_i, out_ready,
    output in_ready, out_valid, imm_o, err_o
  );

  modport master (
    output in_valid, imm_i, mode_i, out_ready,
    input  in_ready, out_valid, imm_o, err_o
  );
endinterface

// File: rtl/imm_extend_stage.sv
// Registered immediate extension (sign/zero/LUI) with a 2-entry skid buffer.
// Ports: clk, rst_n (async low), bus (imm_extend_if.slave). Macro: IMM_EXT_LUI_EN.
module imm_extend_stage #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  imm_extend_if.slave  bus
);

  // state bits are {out_valid, skid_full}
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t           state;
  logic [OUT_W-1:0] out_q;
  logic [OUT_W-1:0] skid_q;
  logic             out_err_q;
  logic             skid_err_q;
  logic [OUT_W-1:0] ext;
  logic             ext_err;
  logic [IN_W-1:0]  imm;
  logic             in_xfer;
  logic             out_xfer;

`ifdef IMM_EXT_LUI_EN
  localparam int PAD = OUT_W - IN_W;
`endif

  assign imm           = bus.imm_i;
  assign bus.in_ready  = ~state[0];
  assign bus.out_valid = state[1];
  assign bus.imm_o     = out_q;
  assign bus.err_o     = out_err_q;

  assign in_xfer  = bus.in_valid & ~state[0];
  assign out_xfer = state[1] & bus.out_ready;

  always_comb begin
    ext     = '0;
    ext_err = 1'b0;
    unique case (1'b1)
      (bus.mode_i == 2'b00): ext = OUT_W'($signed(imm));
      (bus.mode_i == 2'b01): ext = OUT_W'(imm);
`ifdef IMM_EXT_LUI_EN
      (bus.mode_i == 2'b10): ext = OUT_W'(imm) << PAD;
`endif
      default:               ext_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      out_q      <= '0;
      out_err_q  <= 1'b0;
      skid_q     <= '0;
      skid_err_q <= 1'b0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_xfer) begin
            out_q     <= ext;
            out_err_q <= ext_err;
            state     <= ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            out_q     <= ext;
            out_err_q <= ext_err;
          end else if (out_xfer) begin
            state <= EMPTY;
          end else if (in_xfer) begin
            skid_q     <= ext;
            skid_err_q <= ext_err;
            state      <= FULL;
          end
        end
        FULL: begin
          if (out_xfer) begin
            out_q     <= skid_q;
            out_err_q <= skid_err_q;
            state     <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule
